pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the pipelined CPU, replacing per-stage fixed latches.
//  Carries one data bundle and one control bundle with a valid/ready handshake, flush (bubble insertion)
//  and an optional 2-entry skid buffer so in_ready is fully registered. Sits between IF/ID/EX/MEM/WB.
//  Control bits of an invalid (bubble) slot are forced to BUBBLE_CTRL so no spurious reg/mem write occurs.
// PARAMETERS
//  DATA_W       160     width of data bundle (PC, opA, opB, extImm, instruction)
//  CTRL_W       20      width of control bundle (regDst..move, branch flags)
//  SKID         1       1: 2-entry skid buffer, registered in_ready; 0: single entry, in_ready combinational
//  BUBBLE_CTRL  0       CTRL_W-bit value driven on out_ctrl whenever out_valid=0
// PORTS
//  CLK        in   1        clock, all state updates on posedge
//  RST        in   1        asynchronous active-high reset
//  flush      in   1        synchronous squash of all held entries (branch/jump taken)
//  in_valid   in   1        upstream entry valid
//  in_ready   out  1        stage can accept; transfer when in_valid & in_ready
//  in_data    in   DATA_W   upstream data bundle
//  in_ctrl    in   CTRL_W   upstream control bundle
//  out_valid  out  1        entry presented downstream
//  out_ready  in   1        downstream accepts; transfer when out_valid & out_ready
//  out_data   out  DATA_W   head entry data (held value when out_valid=0)
//  out_ctrl   out  CTRL_W   head entry control; BUBBLE_CTRL when out_valid=0
//  occupancy  out  2        entries held: 0,1,2 (2 only when SKID=1)
// BEHAVIOUR
//  Reset (async, RST=1): state EMPTY, out_valid=0, occupancy=0, out_ctrl=BUBBLE_CTRL, out_data=0,
//   in_ready=1; both entry registers cleared. Release takes effect on first posedge after RST falls.
//  Latency: 1 cycle in_valid&in_ready -> out_valid, when stage empty. Throughput 1 entry/cycle.
//  SKID=1 FSM (state = occupancy; in_ready = (state!=FULL2), registered, never depends on out_ready):
//   EMPTY: accept -> ONE (main<=in).
//   ONE  : accept&~pop -> FULL2 (skid<=in); pop&~accept -> EMPTY; accept&pop -> ONE (main<=in).
//   FULL2: in_ready=0; pop -> ONE (main<=skid); no pop -> hold.
//   accept = in_valid&in_ready; pop = out_valid&out_ready. Order preserved: main always oldest.
//  SKID=0: one entry; in_ready = ~out_valid | out_ready (combinational);
//   accept loads main, pop&~accept -> EMPTY.
//  Flush: at posedge with flush=1 -> EMPTY regardless of accept/pop that cycle; in-flight input
//   is discarded (upstream sees accept if in_ready was 1 and must treat the entry as consumed).
//   Flush has priority over every other event; RST has priority over flush.
//  Data registers load only on accept or skid->main move (low toggle); never load on flush.
//  out_ctrl = out_valid ? main_ctrl : BUBBLE_CTRL (combinational mux on the output).
//  Stall: out_ready=0 holds out_data/out_ctrl/out_valid stable until pop (handshake rule).
//  Upstream rule: in_valid/in_data/in_ctrl held stable while in_valid & ~in_ready.
//  No overflow possible: FULL2 deasserts in_ready; an in_valid in FULL2 is simply not accepted.
// TESTING
//  1 Reset mid-stream: FULL2 with 0xA/0xB, assert RST between edges -> out_valid=0, occupancy=0,
//    out_ctrl=BUBBLE_CTRL immediately, no posedge needed.
//  2 Streaming: in_valid=1, out_ready=1, data 1..16 -> out 1..16 in order, 1-cycle latency, no gaps.
//  3 Backpressure: out_ready=0 after 0x11,0x22 accepted -> occupancy=2, in_ready=0 next cycle,
//    out_data=0x11 held; out_ready=1 -> 0x11 then 0x22, in_ready returns 1 after first pop.
//  4 Flush with simultaneous accept+pop in ONE -> next cycle out_valid=0, occupancy=0,
//    out_ctrl=BUBBLE_CTRL; input entry never appears at output.
//  5 Bubble control: BUBBLE_CTRL=0, in_ctrl=0xFFFFF then pop -> out_ctrl=0 whenever out_valid=0.
//  6 SKID=0 build: repeat 2-3 -> max occupancy 1, in_ready tracks out_ready same cycle, order kept.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready inter-stage pipeline register with flush, bubble control and optional skid entry
module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 20,
  parameter int SKID = 1,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  logic [1:0]        occ;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              accept, pop, load_main, load_skid;
  assign out_valid = occ != 2'd0;
  // With the skid entry in_ready comes straight off the occupancy flops, cutting the ready chain
  assign in_ready  = (SKID != 0) ? occ != 2'd2 : ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign load_main = ~flush & ((occ == 2'd2) ? pop : accept & ((occ == 2'd0) | pop));
  assign load_skid = (SKID != 0) & ~flush & accept & ~pop & (occ == 2'd1);
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : BUBBLE_CTRL;
  assign occupancy = occ;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occ       <= 2'd0;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      occ <= flush ? 2'd0 : occ + {1'b0, accept} - {1'b0, pop};
      if (load_main) begin
        main_data <= (occ == 2'd2) ? skid_data : in_data;
        main_ctrl <= (occ == 2'd2) ? skid_ctrl : in_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end
endmodule
